// File: rtl/serial_demux4_rx.sv
// Receive side of the 4:1 serial lane: rebuilds N-bit words from a slot-ordered bit
// stream and offers each completed word through a one-entry valid/ready holding register.
module serial_demux4_rx #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_in,
  input  logic            bit_valid,
  input  logic            frame_start,
  output logic [N-1:0]    data_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] sel_out,
  output logic            sync_err,
  output logic            overflow,
  output logic            o_dbg_state
);

  // Handshake: a word moves to the consumer on a rising edge where out_valid && out_ready;
  // out_valid never drops and data_out never changes until that transfer occurs.

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);

  state_t          r_state;
  logic [SELW-1:0] r_sel;
  logic [N-1:0]    r_shift;
  logic [N-1:0]    r_data;
  logic            r_valid;
  logic            r_sync_err;
  logic            r_overflow;

  logic [N-1:0]    w_merged;
  logic            w_resync;
  logic            w_done;
  logic            w_xfer;

  always_comb begin
    w_merged        = r_shift;
    w_merged[r_sel] = bit_in;
  end

  // A mid-word frame_start restarts the word, so it can never also complete one.
  assign w_resync = bit_valid && frame_start && (r_state == COLLECT) && (r_sel != '0);
  assign w_done   = bit_valid && (r_state == COLLECT) && !w_resync && (r_sel == SEL_LAST);
  assign w_xfer   = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_shift    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bit_valid && frame_start) begin
            r_shift <= {{(N-1){1'b0}}, bit_in};
            r_sel   <= SELW'(1);
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_resync) begin
            r_shift    <= {{(N-1){1'b0}}, bit_in};
            r_sel      <= SELW'(1);
            r_sync_err <= 1'b1;
          end else if (w_done) begin
            r_shift <= '0;
            r_sel   <= '0;
          end else if (bit_valid) begin
            r_shift <= w_merged;
            r_sel   <= r_sel + SELW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= '0;
          r_shift <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || out_ready) begin
        r_data  <= w_merged;
        r_valid <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out    = r_data;
  assign out_valid   = r_valid;
  assign sel_out     = r_sel;
  assign sync_err    = r_sync_err;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_demux4_rx.sv
// Bench for serial_demux4_rx: fixed vector table, directed corner sequences, and a random
// phase checked against a bit-queue reference model.
module tb_serial_demux4_rx;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, bit_in, bit_valid, frame_start, out_ready;
  logic [3:0] data_out;
  logic       out_valid;
  logic [1:0] sel_out;
  logic       sync_err, overflow, dbg_state;

  int checks = 0;
  int errors = 0;

  serial_demux4_rx #(.N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .sel_out(sel_out), .sync_err(sync_err),
    .overflow(overflow), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the current word kept in arrival order.
  logic       m_synced;
  logic       m_bits[$];
  logic [3:0] m_data;
  logic       m_valid, m_err, m_ovf;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       bv, fs, b, rdy;
    logic [1:0] e_sel;
    logic       e_valid;
    logic [3:0] e_data;
    logic       e_err;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic bv, input logic fs, input logic b,
                            input logic rdy);
    logic       done;
    logic [3:0] word;
    done = 1'b0;
    word = '0;
    if (r) begin
      m_synced = 1'b0;
      m_bits.delete();
      m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      m_err = 1'b0;
      if (bv) begin
        if (fs) begin
          if (m_synced && m_bits.size() != 0) m_err = 1'b1;
          m_bits.delete();
          m_synced = 1'b1;
          m_bits.push_back(b);
        end else if (m_synced) begin
          m_bits.push_back(b);
        end
        if (m_bits.size() == N) begin
          for (int k = 0; k < N; k++) word = word + (4'(m_bits[k]) << k);
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_data = word; m_valid = 1'b1;
          exp_q.push_back(word);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare all outputs after the edge.
  task automatic step(input logic r, input logic bv, input logic fs, input logic b,
                      input logic rdy);
    rst = r; bit_valid = bv; frame_start = fs; bit_in = b; out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, bv, fs, b, rdy);
    chk("sel_out", 32'(sel_out), 32'(m_bits.size()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid || r) chk("data_out", 32'(data_out), 32'(m_data));
  endtask

  task automatic send_word(input logic [3:0] w, input logic fs_first, input logic rdy);
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, (k == 0) && fs_first, w[k], rdy);
  endtask

  task automatic add_vec(input logic bv, input logic fs, input logic b, input logic rdy,
                         input logic [1:0] s, input logic v, input logic [3:0] d,
                         input logic e, input logic o);
    vec_t t;
    t.bv = bv; t.fs = fs; t.b = b; t.rdy = rdy;
    t.e_sel = s; t.e_valid = v; t.e_data = d; t.e_err = e; t.e_ovf = o;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    m_synced = 1'b0; m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_ovf = 1'b0;

    // bits 0,1,0,1 then 1,1,0,0 / 1,0,0,0 back-to-back, out_ready held high
    add_vec(1, 1, 0, 1, 2'd1, 0, 4'h0, 0, 0);
    add_vec(1, 0, 1, 1, 2'd2, 0, 4'h0, 0, 0);
    add_vec(1, 0, 0, 1, 2'd3, 0, 4'h0, 0, 0);
    add_vec(1, 0, 1, 1, 2'd0, 1, 4'b1010, 0, 0);
    add_vec(0, 0, 0, 1, 2'd0, 0, 4'b1010, 0, 0);
    add_vec(1, 1, 1, 1, 2'd1, 0, 4'h0, 0, 0);
    add_vec(1, 0, 1, 1, 2'd2, 0, 4'h0, 0, 0);
    add_vec(1, 0, 0, 1, 2'd3, 0, 4'h0, 0, 0);
    add_vec(1, 0, 0, 1, 2'd0, 1, 4'b0011, 0, 0);
    add_vec(1, 0, 1, 1, 2'd1, 0, 4'h0, 0, 0);
    add_vec(1, 0, 0, 1, 2'd2, 0, 4'h0, 0, 0);
    add_vec(1, 0, 0, 1, 2'd3, 0, 4'h0, 0, 0);
    add_vec(1, 0, 0, 1, 2'd0, 1, 4'b0001, 0, 0);
    add_vec(0, 0, 0, 1, 2'd0, 0, 4'h0, 0, 0);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data", 32'(data_out), 0);
    chk("reset_sel", 32'(sel_out), 0);

    foreach (vecs[i]) begin
      step(0, vecs[i].bv, vecs[i].fs, vecs[i].b, vecs[i].rdy);
      chk($sformatf("vec%0d_sel", i), 32'(sel_out), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_err", i), 32'(sync_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].e_data));
    end

    // overflow: hold 4'b1111, drop 4'b0000, then drain once
    step(1, 0, 0, 0, 0);
    send_word(4'b1111, 1, 0);
    send_word(4'b0000, 0, 0);
    chk("ovf_data_held", 32'(data_out), 32'hF);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_valid_held", 32'(out_valid), 1);
    step(0, 0, 0, 0, 1);
    chk("ovf_drained", 32'(out_valid), 0);
    step(0, 0, 0, 0, 1);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_no_second", 32'(out_valid), 0);

    // mid-word frame_start
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 1, 1);
    chk("resync_err", 32'(sync_err), 1);
    chk("resync_sel", 32'(sel_out), 1);
    step(0, 1, 0, 0, 1);
    chk("resync_err_pulse", 32'(sync_err), 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    chk("resync_word", 32'(data_out), 32'b1101);
    chk("resync_valid", 32'(out_valid), 1);

    // reset mid-word discards partial bits
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_sel", 32'(sel_out), 0);
    send_word(4'b0110, 1, 1);
    chk("rst_word", 32'(data_out), 32'b0110);
    chk("rst_word_valid", 32'(out_valid), 1);

    // IDLE ignores unframed bits; gaps between bits are harmless
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    chk("idle_ignore_sel", 32'(sel_out), 0);
    for (int k = 0; k < N; k++) begin
      step(0, 1, (k == 0), 1'((4'b1001 >> k) & 1), 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 1);
    end
    chk("gap_word", 32'(data_out), 32'b1001);

    // random phase against the model
    step(1, 0, 0, 0, 0);
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0));
    end
    chk("rand_words_seen", 32'(exp_q.size() > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
